hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_pkg.sv | 12 +
 rtl/hazard_sb_cnt.sv | 41 ++++
 rtl/hazard_scoreboard.sv | 125 ++++++++++++
 tb/tb_hazard_scoreboard.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared defaults and producer-latency constants for the hazard scoreboard.
package hazard_pkg;

    localparam int unsigned REG_W_DEF = 5;
    localparam int unsigned LAT_W_DEF = 3;

    localparam int unsigned LAT_ALU  = 1;
    localparam int unsigned LAT_LOAD = 2;
    localparam int unsigned LAT_HILO = 1;
    localparam int unsigned LAT_CP0  = 2;

endpackage

// File: rtl/hazard_sb_cnt.sv
// One per-register "cycles until forwardable" counter: clear, load, decrement or hold.
module hazard_sb_cnt
    import hazard_pkg::*;
#(
    parameter int unsigned LAT_W = LAT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             adv_i,
    input  logic             load_i,
    input  logic [LAT_W-1:0] load_val_i,
    output logic [LAT_W-1:0] cnt_o
);

    logic [LAT_W-1:0] cnt_d;
    logic [LAT_W-1:0] cnt_q;

    // Clear beats load; load replaces this cycle's decrement.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (adv_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - LAT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Latency-counting register scoreboard producing pipeline stall/flush controls.
// Optional cycle counters are built when HAZARD_PERF_EN is defined.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned REG_W    = REG_W_DEF,
    parameter int unsigned LAT_W    = LAT_W_DEF,
    parameter int unsigned NUM_REGS = 2 ** REG_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [REG_W-1:0]    rs_d,
    input  logic [REG_W-1:0]    rt_d,
    input  logic                rs_use_d,
    input  logic                rt_use_d,
    input  logic                early_d,
    input  logic                issue_d,
    input  logic                wen_d,
    input  logic [REG_W-1:0]    dst_d,
    input  logic [LAT_W-1:0]    lat_d,
    input  logic                i_stall,
    input  logic                d_stall,
    input  logic                long_busy_e,
    input  logic                flush_req_m,
    output logic                stall_f,
    output logic                stall_d,
    output logic                stall_e,
    output logic                stall_m,
    output logic                stall_w,
    output logic                flush_d,
    output logic                flush_e,
    output logic                flush_m,
    output logic                flush_w,
    output logic                all_stall,
    output logic [NUM_REGS-1:0] busy_vec
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]         perf_hz_cycles,
    output logic [31:0]         perf_frz_cycles
`endif
);

    logic [LAT_W-1:0] cnt [NUM_REGS];
    logic [LAT_W-1:0] cnt_rs;
    logic [LAT_W-1:0] cnt_rt;
    logic [LAT_W-1:0] cnt_dst;
    logic             raw_haz;
    logic             waw_haz;
    logic             hz_stall;
    logic             advance;
    logic             issue_ev;

    // r0 is hardwired zero, so it never holds a pending result.
    assign cnt[0] = '0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
        hazard_sb_cnt #(
            .LAT_W      (LAT_W)
        ) u_cnt (
            .clk        (clk),
            .rst        (rst),
            .clr_i      (flush_req_m),
            .adv_i      (advance),
            .load_i     (issue_ev && (dst_d == REG_W'(r))),
            .load_val_i (lat_d),
            .cnt_o      (cnt[r])
        );
    end

    // Early (D-stage compare) consumers cannot use the E-stage forward path.
    always_comb begin
        cnt_rs   = cnt[rs_d];
        cnt_rt   = cnt[rt_d];
        cnt_dst  = cnt[dst_d];
        all_stall = i_stall | d_stall | long_busy_e;
        raw_haz  = (rs_use_d && ((cnt_rs > LAT_W'(1)) || ((cnt_rs != '0) && early_d)))
                || (rt_use_d && ((cnt_rt > LAT_W'(1)) || ((cnt_rt != '0) && early_d)));
        waw_haz  = issue_d && wen_d && (dst_d != '0) && (cnt_dst > lat_d);
        hz_stall = issue_d && (raw_haz || waw_haz) && !flush_req_m;
        advance  = !all_stall;
        issue_ev = advance && issue_d && !hz_stall && wen_d && (dst_d != '0);
        stall_f  = all_stall | hz_stall;
        stall_d  = all_stall | hz_stall;
        stall_e  = all_stall;
        stall_m  = all_stall;
        stall_w  = all_stall;
        flush_d  = flush_req_m;
        flush_e  = (hz_stall && !all_stall) || flush_req_m;
        flush_m  = flush_req_m;
        flush_w  = flush_req_m;
    end

    always_comb begin
        busy_vec = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            busy_vec[r] = (cnt[r] != '0);
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_hz_d;
    logic [31:0] perf_hz_q;
    logic [31:0] perf_frz_d;
    logic [31:0] perf_frz_q;

    always_comb begin
        perf_hz_d  = perf_hz_q + 32'(hz_stall && !all_stall);
        perf_frz_d = perf_frz_q + 32'(all_stall);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_hz_q  <= '0;
            perf_frz_q <= '0;
        end else begin
            perf_hz_q  <= perf_hz_d;
            perf_frz_q <= perf_frz_d;
        end
    end

    assign perf_hz_cycles  = perf_hz_q;
    assign perf_frz_cycles = perf_frz_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized and directed bench for hazard_scoreboard against a per-register countdown model.
module tb_hazard_scoreboard;

    localparam int unsigned REG_W    = 5;
    localparam int unsigned LAT_W    = 3;
    localparam int unsigned NUM_REGS = 32;

    logic                clk = 1'b0;
    logic                rst;
    logic [REG_W-1:0]    rs_d, rt_d, dst_d;
    logic                rs_use_d, rt_use_d, early_d, issue_d, wen_d;
    logic [LAT_W-1:0]    lat_d;
    logic                i_stall, d_stall, long_busy_e, flush_req_m;
    logic                stall_f, stall_d, stall_e, stall_m, stall_w;
    logic                flush_d, flush_e, flush_m, flush_w, all_stall;
    logic [NUM_REGS-1:0] busy_vec;
`ifdef HAZARD_PERF_EN
    logic [31:0]         perf_hz_cycles, perf_frz_cycles;
`endif

    hazard_scoreboard #(.REG_W(REG_W), .LAT_W(LAT_W)) dut (
        .clk(clk), .rst(rst),
        .rs_d(rs_d), .rt_d(rt_d), .rs_use_d(rs_use_d), .rt_use_d(rt_use_d),
        .early_d(early_d), .issue_d(issue_d), .wen_d(wen_d), .dst_d(dst_d), .lat_d(lat_d),
        .i_stall(i_stall), .d_stall(d_stall), .long_busy_e(long_busy_e), .flush_req_m(flush_req_m),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m), .stall_w(stall_w),
        .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m), .flush_w(flush_w),
        .all_stall(all_stall), .busy_vec(busy_vec)
`ifdef HAZARD_PERF_EN
        , .perf_hz_cycles(perf_hz_cycles), .perf_frz_cycles(perf_frz_cycles)
`endif
    );

    always #5 clk = ~clk;

    int          n_total = 0;
    int          n_pass  = 0;
    int          m_cnt [NUM_REGS];
    logic [31:0] m_hz, m_frz;
    int          n_hz_obs;
    int          n_frz_obs;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, got, exp);
    endtask

    function automatic bit src_haz(input logic [REG_W-1:0] s, input logic use_s);
        return use_s && ((m_cnt[s] > 1) || ((m_cnt[s] > 0) && early_d));
    endfunction

    task automatic idle();
        rs_d = '0; rt_d = '0; dst_d = '0; lat_d = '0;
        rs_use_d = 0; rt_use_d = 0; early_d = 0; issue_d = 0; wen_d = 0;
        i_stall = 0; d_stall = 0; long_busy_e = 0; flush_req_m = 0; rst = 0;
    endtask

    // Compare current outputs to the model, then let one clock edge happen and advance the model.
    task automatic cycle();
        bit                  frz, raw, waw, hz, ev;
        logic [9:0]          exp_ctl, got_ctl;
        logic [NUM_REGS-1:0] exp_busy;
        #1;
        frz = i_stall || d_stall || long_busy_e;
        raw = src_haz(rs_d, rs_use_d) || src_haz(rt_d, rt_use_d);
        waw = issue_d && wen_d && (dst_d != 0) && (m_cnt[dst_d] > int'(lat_d));
        hz  = issue_d && (raw || waw) && !flush_req_m;
        ev  = !frz && issue_d && !hz && wen_d && (dst_d != 0);
        exp_ctl = {frz || hz, frz || hz, frz, frz, frz, flush_req_m,
                   (hz && !frz) || flush_req_m, flush_req_m, flush_req_m, frz};
        got_ctl = {stall_f, stall_d, stall_e, stall_m, stall_w, flush_d,
                   flush_e, flush_m, flush_w, all_stall};
        for (int r = 0; r < NUM_REGS; r++) exp_busy[r] = (m_cnt[r] != 0);
        check("ctl{stall_f..w,flush_d..w,all_stall}", 64'(got_ctl), 64'(exp_ctl));
        check("busy_vec", 64'(busy_vec), 64'(exp_busy));
`ifdef HAZARD_PERF_EN
        check("perf_hz_cycles", 64'(perf_hz_cycles), 64'(m_hz));
        check("perf_frz_cycles", 64'(perf_frz_cycles), 64'(m_frz));
`endif
        if (hz && !frz) n_hz_obs++;
        if (frz) n_frz_obs++;
        @(posedge clk);
        if (rst) begin
            foreach (m_cnt[r]) m_cnt[r] = 0;
            m_hz = 0; m_frz = 0;
        end else begin
            m_hz  = m_hz + 32'(hz && !frz);
            m_frz = m_frz + 32'(frz);
            if (flush_req_m) begin
                foreach (m_cnt[r]) m_cnt[r] = 0;
            end else if (!frz) begin
                foreach (m_cnt[r]) if (m_cnt[r] > 0) m_cnt[r]--;
                if (ev) m_cnt[dst_d] = int'(lat_d);
            end
        end
        @(negedge clk);
    endtask

    task automatic wr(input int dst, input int lat);
        idle(); issue_d = 1; wen_d = 1; dst_d = REG_W'(dst); lat_d = LAT_W'(lat);
    endtask

    initial begin
        idle(); rst = 1;
        @(negedge clk); @(negedge clk);
        foreach (m_cnt[r]) m_cnt[r] = 0;
        m_hz = 0; m_frz = 0;
        idle(); rst = 1; cycle();
        n_hz_obs = 0; n_frz_obs = 0;

        // load r8 then dependent ADD: one hazard cycle
        wr(8, 2); cycle();
        wr(11, 1); rs_d = 8; rs_use_d = 1;
        #1 check("r28_stall_d", 64'(stall_d), 1); check("r28_flush_e", 64'(flush_e), 1); cycle();
        wr(11, 1); rs_d = 8; rs_use_d = 1;
        #1 check("r28_issue_stall_d", 64'(stall_d), 0); check("r28_busy8_set", 64'(busy_vec[8]), 1); cycle();
        idle(); #1 check("r28_busy8_clr", 64'(busy_vec[8]), 0); cycle();

        // ALU then early-compare branch
        wr(9, 1); cycle();
        idle(); issue_d = 1; rs_d = 9; rs_use_d = 1; early_d = 1;
        #1 check("r29_early_stall", 64'(stall_d), 1); cycle();
        idle(); issue_d = 1; rs_d = 9; rs_use_d = 1; early_d = 1;
        #1 check("r29_early_go", 64'(stall_d), 0); cycle();
        wr(9, 1); cycle();
        idle(); issue_d = 1; rs_d = 9; rs_use_d = 1;
        #1 check("r29_late_nostall", 64'(stall_d), 0); cycle();

        // external freeze holds the counters
        wr(8, 2); cycle();
        repeat (3) begin
            idle(); d_stall = 1;
            #1 check("r30_stall_e", 64'(stall_e), 1); check("r30_stall_w", 64'(stall_w), 1);
            check("r30_flush_e", 64'(flush_e), 0); check("r30_busy8", 64'(busy_vec[8]), 1);
            cycle();
        end
        idle(); #1 check("r30_busy8_held", 64'(busy_vec[8]), 1); cycle();
        idle(); cycle();
        idle(); #1 check("r30_busy8_clr", 64'(busy_vec[8]), 0); cycle();

        // long MUL then short ALU to same destination
        wr(10, 5); cycle();
        idle(); cycle();
        repeat (3) begin
            wr(10, 1); #1 check("r31_waw_stall", 64'(stall_d), 1); cycle();
        end
        wr(10, 1); #1 check("r31_waw_go", 64'(stall_d), 0); cycle();
        idle(); cycle();

        // flush overrides the hazard and clears everything
        wr(8, 2); cycle();
        idle(); issue_d = 1; rs_d = 8; rs_use_d = 1; flush_req_m = 1;
        #1 check("r32_stall_d", 64'(stall_d), 0); check("r32_flush_d", 64'(flush_d), 1);
        check("r32_flush_e", 64'(flush_e), 1); check("r32_flush_w", 64'(flush_w), 1); cycle();
        idle(); #1 check("r32_busy_zero", 64'(busy_vec), 0); cycle();

        // writes to r0 never create hazards
        wr(0, 2); cycle();
        idle(); issue_d = 1; rs_use_d = 1; rt_use_d = 1; early_d = 1;
        #1 check("r33_r0_nostall", 64'(stall_d), 0); check("r33_busy0", 64'(busy_vec[0]), 0); cycle();

        check("dir_hz_cycles_model", 64'(n_hz_obs), 5);
        check("dir_frz_cycles_model", 64'(n_frz_obs), 3);
`ifdef HAZARD_PERF_EN
        check("r33_perf_hz", 64'(perf_hz_cycles), 5);
        check("r33_perf_frz", 64'(perf_frz_cycles), 3);
`endif

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            idle();
            rst         = ($urandom % 300) == 0;
            issue_d     = ($urandom % 4) != 0;
            wen_d       = ($urandom % 3) != 0;
            rs_use_d    = ($urandom % 3) != 0;
            rt_use_d    = ($urandom % 2) != 0;
            early_d     = ($urandom % 5) == 0;
            rs_d        = REG_W'(($urandom % 8 == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7));
            rt_d        = REG_W'($urandom_range(0, 7));
            dst_d       = REG_W'(($urandom % 8 == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7));
            lat_d       = LAT_W'($urandom_range(0, 7));
            i_stall     = ($urandom % 16) == 0;
            d_stall     = ($urandom % 20) == 0;
            long_busy_e = ($urandom % 24) == 0;
            flush_req_m = ($urandom % 40) == 0;
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
